multiplexor_na1_secuencial: RTL and testbench

MULTIPLEXOR_NA1_SECUENCIAL -- requirements
Module: multiplexor_na1_secuencial

---
 rtl/multiplexor_na1_secuencial.sv | 133 +++++++++++++
 tb/tb_multiplexor_na1_secuencial.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_na1_secuencial.sv
// ---------------------------------------------------------------------------
// multiplexor_na1_secuencial
//
// Registered N-to-1 multiplexer with two operating modes:
// - Manual mode (MODE = 0): the channel picked by SEL is loaded into R.
// - Scan mode (MODE = 1): the block visits every channel in round-robin
//   order and stays on each one for DWELL enabled cycles.
//
// Ports
//   CLK    : clock; every state update happens on the rising edge.
//   RST_N  : synchronous, active-low reset.
//   L      : flattened input channels; channel k is L[k*WIDTH +: WIDTH].
//   SEL    : channel index in manual mode, and the start channel of a scan.
//   MODE   : 0 = manual select, 1 = round-robin scan.
//   EN     : 1 = update / advance; 0 = freeze all state.
//   R      : registered data of the selected channel.
//   CH     : index of the channel currently driving R.
//   VALID  : one-cycle pulse whenever R is loaded from a new channel index.
//   ERR    : set while the manual SEL points past the last channel.
// ---------------------------------------------------------------------------
module multiplexor_na1_secuencial #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N*WIDTH-1:0] L,
  input  logic [SELW-1:0]    SEL,
  input  logic               MODE,
  input  logic               EN,
  output logic [WIDTH-1:0]   R,
  output logic [SELW-1:0]    CH,
  output logic               VALID,
  output logic               ERR
);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // One bit wider than SEL so that "SEL < N" also works when N is a power of 2.
  localparam logic [SELW:0]   NUM_CH     = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(N-1);
  localparam logic [7:0]      DWELL_LAST = 8'(DWELL-1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [7:0]        dwell_q, dwell_d;

  logic [WIDTH-1:0]  chan [N];
  logic              selOk;
  logic [SELW-1:0]   startCh;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign chan[k] = L[k*WIDTH +: WIDTH];
  end

  assign selOk   = ({1'b0, SEL} < NUM_CH);
  assign startCh = selOk ? SEL : '0;

  // State register; reset is synchronous and overrides EN, MODE and SEL.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_MANUAL;
      r_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state logic. With EN low every register holds and VALID drops.
  // A mode change is handled before any dwell advance, so entering scan
  // always restarts from SEL with a cleared dwell counter. R is loaded from
  // the channel that CH is about to point at, keeping R and CH aligned.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    err_d   = err_q;
    dwell_d = dwell_q;

    if (EN) begin
      state_d = MODE ? ST_SCAN : ST_MANUAL;
      if (MODE) begin
        err_d = 1'b0;
        if (state_q == ST_MANUAL) begin
          ch_d    = startCh;
          dwell_d = '0;
          valid_d = 1'b1;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
          valid_d = 1'b1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
        r_d = chan[ch_d];
      end else begin
        dwell_d = '0;
        if (selOk) begin
          r_d     = chan[SEL];
          ch_d    = SEL;
          err_d   = 1'b0;
          valid_d = (SEL != ch_q);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  assign R     = r_q;
  assign CH    = ch_q;
  assign VALID = valid_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_multiplexor_na1_secuencial.sv
// ---------------------------------------------------------------------------
// tb_multiplexor_na1_secuencial
//
// Drives three instances of multiplexor_na1_secuencial from shared inputs:
//   A: N=4, DWELL=2    B: N=5, DWELL=3    C: N=4, DWELL=1   (all WIDTH=4)
// A reference model tracks each instance as a scan start index plus a count
// of enabled scan cycles, from which the current channel is derived.
// ---------------------------------------------------------------------------
module tb_multiplexor_na1_secuencial;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [19:0] lBus = 20'hEDCBA;
  logic [2:0]  sel = 3'd0;
  logic        mode = 1'b0;
  logic        en = 1'b0;

  logic [3:0] rA, rB, rC;
  logic [1:0] chA, chC;
  logic [2:0] chB;
  logic       vA, vB, vC, eA, eB, eC;

  int checkCount = 0;
  int failCount  = 0;

  int cfgN[3]    = '{4, 5, 4};
  int cfgD[3]    = '{2, 3, 1};
  int cfgSelW[3] = '{2, 3, 2};

  int mR[3], mCh[3], mValid[3], mErr[3], mScan[3], mStart[3], mCnt[3];

  always #5 clk = ~clk;

  multiplexor_na1_secuencial #(.WIDTH(4), .N(4), .DWELL(2)) dutA (
    .CLK(clk), .RST_N(rstN), .L(lBus[15:0]), .SEL(sel[1:0]), .MODE(mode),
    .EN(en), .R(rA), .CH(chA), .VALID(vA), .ERR(eA));

  multiplexor_na1_secuencial #(.WIDTH(4), .N(5), .DWELL(3)) dutB (
    .CLK(clk), .RST_N(rstN), .L(lBus), .SEL(sel), .MODE(mode),
    .EN(en), .R(rB), .CH(chB), .VALID(vB), .ERR(eB));

  multiplexor_na1_secuencial #(.WIDTH(4), .N(4), .DWELL(1)) dutC (
    .CLK(clk), .RST_N(rstN), .L(lBus[15:0]), .SEL(sel[1:0]), .MODE(mode),
    .EN(en), .R(rC), .CH(chC), .VALID(vC), .ERR(eC));

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int chanVal(input int ch);
    return int'((lBus >> (4*ch)) & 20'hF);
  endfunction

  // Behavioural model of one clock edge for instance i.
  task automatic modelStep(input int i, input logic r, input logic m, input logic e, input int s);
    int selSeen;
    if (!r) begin
      mR[i] = 0; mCh[i] = 0; mValid[i] = 0; mErr[i] = 0;
      mScan[i] = 0; mStart[i] = 0; mCnt[i] = 0;
    end else if (!e) begin
      mValid[i] = 0;
    end else begin
      selSeen = s % (1 << cfgSelW[i]);
      if (m) begin
        if (mScan[i] == 0) begin
          mScan[i]  = 1;
          mStart[i] = (selSeen < cfgN[i]) ? selSeen : 0;
          mCnt[i]   = 0;
          mValid[i] = 1;
        end else begin
          mCnt[i]++;
          mValid[i] = (mCnt[i] % cfgD[i] == 0) ? 1 : 0;
        end
        mCh[i]  = (mStart[i] + mCnt[i] / cfgD[i]) % cfgN[i];
        mR[i]   = chanVal(mCh[i]);
        mErr[i] = 0;
      end else begin
        mScan[i] = 0;
        if (selSeen < cfgN[i]) begin
          mValid[i] = (selSeen != mCh[i]) ? 1 : 0;
          mCh[i]    = selSeen;
          mR[i]     = chanVal(selSeen);
          mErr[i]   = 0;
        end else begin
          mValid[i] = 0;
          mErr[i]   = 1;
        end
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("A.R", int'(rA), mR[0]);
    checkOutput("A.CH", int'(chA), mCh[0]);
    checkOutput("A.VALID", int'(vA), mValid[0]);
    checkOutput("A.ERR", int'(eA), mErr[0]);
    checkOutput("B.R", int'(rB), mR[1]);
    checkOutput("B.CH", int'(chB), mCh[1]);
    checkOutput("B.VALID", int'(vB), mValid[1]);
    checkOutput("B.ERR", int'(eB), mErr[1]);
    checkOutput("C.R", int'(rC), mR[2]);
    checkOutput("C.CH", int'(chC), mCh[2]);
    checkOutput("C.VALID", int'(vC), mValid[2]);
    checkOutput("C.ERR", int'(eC), mErr[2]);
  endtask

  // Drive one cycle of inputs away from the edge, step the model on the
  // edge, then compare shortly after.
  task automatic applyStimulus(input logic r, input logic m, input logic e, input int s);
    @(negedge clk);
    rstN = r;
    mode = m;
    en   = e;
    sel  = 3'(s);
    @(posedge clk);
    for (int i = 0; i < 3; i++) modelStep(i, r, m, e, s);
    #1;
    checkAll();
  endtask

  int seqCh[9] = '{3, 3, 0, 0, 1, 1, 2, 2, 3};
  int seqR[9]  = '{13, 13, 10, 10, 11, 11, 12, 12, 13};
  int seqV[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
  int seqC[5]  = '{0, 1, 2, 3, 0};

  initial begin
    // Reset, held for two cycles with other inputs active.
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("rst.R", int'(rA), 0);
    checkOutput("rst.CH", int'(chA), 0);

    // Manual select of channel 2, then a repeat without a new index.
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    checkOutput("man.R", int'(rA), 'hC);
    checkOutput("man.CH", int'(chA), 2);
    checkOutput("man.VALID", int'(vA), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    checkOutput("man.VALID2", int'(vA), 0);

    // Scan entry from SEL=3 on A (DWELL=2).
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 3);
      checkOutput("scan.CH", int'(chA), seqCh[k]);
      checkOutput("scan.R", int'(rA), seqR[k]);
      checkOutput("scan.VALID", int'(vA), seqV[k]);
    end

    // Out-of-range manual select on B (N=5), then the last channel.
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 6);
    checkOutput("err.ERR", int'(eB), 1);
    checkOutput("err.CH", int'(chB), 1);
    checkOutput("err.R", int'(rB), 'hB);
    applyStimulus(1'b1, 1'b0, 1'b1, 4);
    checkOutput("err.ERR2", int'(eB), 0);
    checkOutput("err.R2", int'(rB), 'hE);

    // Freeze mid-dwell on B (DWELL=3), then resume the remaining dwell.
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      checkOutput("frz.CH", int'(chB), 0);
      checkOutput("frz.VALID", int'(vB), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    checkOutput("frz.CH1", int'(chB), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    checkOutput("frz.CH2", int'(chB), 1);
    checkOutput("frz.VALID2", int'(vB), 1);

    // Reset in the middle of a scan, then restart from SEL.
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    checkOutput("rst2.CH", int'(chB), 0);
    checkOutput("rst2.R", int'(rB), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("rst2.restart", int'(chA), 1);

    // DWELL=1 on C: one channel per cycle, VALID held high.
    applyStimulus(1'b1, 1'b0, 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 0);
      checkOutput("d1.CH", int'(chC), seqC[k]);
      checkOutput("d1.VALID", int'(vC), 1);
    end

    // Randomized traffic with occasional resets and data changes.
    for (int k = 0; k < 600; k++) begin
      logic r, m, e;
      int s;
      if ($urandom_range(0, 3) == 0) lBus = 20'($urandom);
      r = ($urandom_range(0, 40) != 0);
      m = ($urandom_range(0, 9) < 5) ? mode : ~mode;
      e = ($urandom_range(0, 4) != 0);
      s = int'($urandom_range(0, 7));
      applyStimulus(r, m, e, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
